// File: rtl/mem_bus_arbiter.sv
// Two-port Sysbus arbiter: grants icache (port 0) or dcache (port 1) one full line transaction.
// Define MEM_BUS_ARB_FIXED_PRIO_EN for fixed priority (port 1 wins ties); default is round-robin.
module mem_bus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8,
    parameter int RW_BIT         = 11
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      p0_bus_reqcyc,
    output logic                      p0_bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] p0_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  p0_bus_reqtag,
    output logic                      p0_bus_respcyc,
    input  logic                      p0_bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] p0_bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  p0_bus_resptag,
    input  logic                      p1_bus_reqcyc,
    output logic                      p1_bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] p1_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  p1_bus_reqtag,
    output logic                      p1_bus_respcyc,
    input  logic                      p1_bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] p1_bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  p1_bus_resptag,
    output logic                      m_bus_reqcyc,
    input  logic                      m_bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] m_bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
    input  logic                      m_bus_respcyc,
    output logic                      m_bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag
);

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, REQ, WDATA, RDATA} state_t;

    state_t        state_q;
    logic          grant_q;
    logic          is_read_q;
    logic [BW-1:0] beat_q;
`ifndef MEM_BUS_ARB_FIXED_PRIO_EN
    logic          last_q;
`endif

    logic                      grant_d;
    logic                      is_read_d;
    logic                      tie_winner;
    logic                      g_reqcyc;
    logic                      g_respack;
    logic [BUS_DATA_WIDTH-1:0] g_req;
    logic [BUS_TAG_WIDTH-1:0]  g_reqtag;
    logic                      pass_req;
    logic                      pass_resp;
    logic                      req_hs;
    logic                      resp_hs;
    logic                      data_hs;

`ifdef MEM_BUS_ARB_FIXED_PRIO_EN
    assign tie_winner = 1'b1;
`else
    assign tie_winner = ~last_q;
`endif

    assign grant_d   = (p0_bus_reqcyc & p1_bus_reqcyc) ? tie_winner : p1_bus_reqcyc;
    assign is_read_d = grant_d ? p1_bus_reqtag[RW_BIT] : p0_bus_reqtag[RW_BIT];

    assign g_reqcyc  = grant_q ? p1_bus_reqcyc  : p0_bus_reqcyc;
    assign g_respack = grant_q ? p1_bus_respack : p0_bus_respack;
    assign g_req     = grant_q ? p1_bus_req     : p0_bus_req;
    assign g_reqtag  = grant_q ? p1_bus_reqtag  : p0_bus_reqtag;

    // Request path is live in address and write-data phases; response path only in RDATA.
    assign pass_req  = (state_q == REQ) || (state_q == WDATA);
    assign pass_resp = (state_q == RDATA);
    assign req_hs    = pass_req & g_reqcyc & m_bus_reqack;
    assign resp_hs   = pass_resp & m_bus_respcyc & g_respack;
    assign data_hs   = ((state_q == WDATA) & req_hs) | resp_hs;

    always_comb begin
        m_bus_reqcyc   = pass_req & g_reqcyc;
        m_bus_req      = pass_req ? g_req : '0;
        m_bus_reqtag   = pass_req ? g_reqtag : '0;
        m_bus_respack  = resp_hs;
        p0_bus_reqack  = pass_req & ~grant_q & m_bus_reqack;
        p1_bus_reqack  = pass_req &  grant_q & m_bus_reqack;
        p0_bus_respcyc = pass_resp & ~grant_q & m_bus_respcyc;
        p1_bus_respcyc = pass_resp &  grant_q & m_bus_respcyc;
        p0_bus_resp    = (pass_resp & ~grant_q) ? m_bus_resp : '0;
        p1_bus_resp    = (pass_resp &  grant_q) ? m_bus_resp : '0;
        p0_bus_resptag = (pass_resp & ~grant_q) ? m_bus_resptag : '0;
        p1_bus_resptag = (pass_resp &  grant_q) ? m_bus_resptag : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            is_read_q <= 1'b0;
            beat_q    <= '0;
`ifndef MEM_BUS_ARB_FIXED_PRIO_EN
            last_q    <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (p0_bus_reqcyc | p1_bus_reqcyc) begin
                        grant_q   <= grant_d;
                        is_read_q <= is_read_d;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (req_hs) begin
                        beat_q  <= '0;
                        state_q <= is_read_q ? RDATA : WDATA;
                    end
                end
                WDATA, RDATA: begin
                    if (data_hs) begin
                        if (beat_q == LAST_BEAT) begin
                            beat_q  <= '0;
                            state_q <= IDLE;
`ifndef MEM_BUS_ARB_FIXED_PRIO_EN
                            last_q  <= grant_q;
`endif
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, a backpressure sequence,
// and randomized traffic compared every cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;

    localparam int DW = 64;
    localparam int TW = 13;
    localparam int BEATS = 8;
`ifdef MEM_BUS_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          p0_bus_reqcyc, p0_bus_reqack, p0_bus_respcyc, p0_bus_respack;
    logic [DW-1:0] p0_bus_req, p0_bus_resp;
    logic [TW-1:0] p0_bus_reqtag, p0_bus_resptag;
    logic          p1_bus_reqcyc, p1_bus_reqack, p1_bus_respcyc, p1_bus_respack;
    logic [DW-1:0] p1_bus_req, p1_bus_resp;
    logic [TW-1:0] p1_bus_reqtag, p1_bus_resptag;
    logic          m_bus_reqcyc, m_bus_reqack, m_bus_respcyc, m_bus_respack;
    logic [DW-1:0] m_bus_req, m_bus_resp;
    logic [TW-1:0] m_bus_reqtag, m_bus_resptag;

    mem_bus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(BEATS), .RW_BIT(11)) dut (
        .clk(clk), .reset(rst),
        .p0_bus_reqcyc(p0_bus_reqcyc), .p0_bus_reqack(p0_bus_reqack), .p0_bus_req(p0_bus_req),
        .p0_bus_reqtag(p0_bus_reqtag), .p0_bus_respcyc(p0_bus_respcyc), .p0_bus_respack(p0_bus_respack),
        .p0_bus_resp(p0_bus_resp), .p0_bus_resptag(p0_bus_resptag),
        .p1_bus_reqcyc(p1_bus_reqcyc), .p1_bus_reqack(p1_bus_reqack), .p1_bus_req(p1_bus_req),
        .p1_bus_reqtag(p1_bus_reqtag), .p1_bus_respcyc(p1_bus_respcyc), .p1_bus_respack(p1_bus_respack),
        .p1_bus_resp(p1_bus_resp), .p1_bus_resptag(p1_bus_resptag),
        .m_bus_reqcyc(m_bus_reqcyc), .m_bus_reqack(m_bus_reqack), .m_bus_req(m_bus_req),
        .m_bus_reqtag(m_bus_reqtag), .m_bus_respcyc(m_bus_respcyc), .m_bus_respack(m_bus_respack),
        .m_bus_resp(m_bus_resp), .m_bus_resptag(m_bus_resptag)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [236:0] act, input logic [236:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: who owns the bus, whether its address beat has been taken,
    // and how many of the BEATS line beats have moved so far.
    int owner   = -1;
    bit m_rd    = 1'b0;
    bit m_addr  = 1'b0;
    int m_cnt   = 0;
    int rr_last = 1;

    always @(posedge clk) begin
        bit oc, ora, hs;
        oc  = (owner == 1) ? p1_bus_reqcyc  : p0_bus_reqcyc;
        ora = (owner == 1) ? p1_bus_respack : p0_bus_respack;
        if (rst) begin
            owner   = -1;
            rr_last = 1;
        end else if (owner < 0) begin
            if (p0_bus_reqcyc || p1_bus_reqcyc) begin
                if (p0_bus_reqcyc && p1_bus_reqcyc) owner = FIXED ? 1 : 1 - rr_last;
                else                                owner = p1_bus_reqcyc ? 1 : 0;
                m_rd   = (owner == 1) ? p1_bus_reqtag[11] : p0_bus_reqtag[11];
                m_addr = 1'b0;
                m_cnt  = 0;
            end
        end else if (!m_addr) begin
            if (oc && m_bus_reqack) m_addr = 1'b1;
        end else begin
            hs = m_rd ? (m_bus_respcyc && ora) : (oc && m_bus_reqack);
            if (hs) begin
                m_cnt++;
                if (m_cnt == BEATS) begin
                    rr_last = owner;
                    owner   = -1;
                end
            end
        end
    end

    function automatic logic [236:0] model_exp();
        bit wr_ph, rd_ph, oc, ora, mine0, mine1;
        logic [DW-1:0] oreq;
        logic [TW-1:0] otag;
        wr_ph = (owner >= 0) && !(m_rd && m_addr);
        rd_ph = (owner >= 0) && m_rd && m_addr;
        oc    = (owner == 1) ? p1_bus_reqcyc  : p0_bus_reqcyc;
        ora   = (owner == 1) ? p1_bus_respack : p0_bus_respack;
        oreq  = (owner == 1) ? p1_bus_req     : p0_bus_req;
        otag  = (owner == 1) ? p1_bus_reqtag  : p0_bus_reqtag;
        mine0 = rd_ph && owner == 0;
        mine1 = rd_ph && owner == 1;
        return {wr_ph && oc, wr_ph ? oreq : 64'h0, wr_ph ? otag : 13'h0,
                rd_ph && ora && m_bus_respcyc,
                wr_ph && owner == 0 && m_bus_reqack, mine0 && m_bus_respcyc,
                mine0 ? m_bus_resp : 64'h0, mine0 ? m_bus_resptag : 13'h0,
                wr_ph && owner == 1 && m_bus_reqack, mine1 && m_bus_respcyc,
                mine1 ? m_bus_resp : 64'h0, mine1 ? m_bus_resptag : 13'h0};
    endfunction

    task automatic step();
        chk("model", {m_bus_reqcyc, m_bus_req, m_bus_reqtag, m_bus_respack,
                      p0_bus_reqack, p0_bus_respcyc, p0_bus_resp, p0_bus_resptag,
                      p1_bus_reqack, p1_bus_respcyc, p1_bus_resp, p1_bus_resptag}, model_exp());
        @(negedge clk);
    endtask

    typedef struct {
        bit rst, c0, c1, rd0, rd1, mack, mrc, ra0, ra1;
        logic [7:0] dat;
        logic [5:0] e;  // {m_reqcyc, p0_reqack, p1_reqack, p0_respcyc, p1_respcyc, m_respack}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rs, bit c0, bit c1, bit rd0, bit rd1, bit mack, bit mrc,
                                bit ra0, bit ra1, logic [7:0] dat, logic [5:0] e);
        vec_t v;
        v.rst = rs; v.c0 = c0; v.c1 = c1; v.rd0 = rd0; v.rd1 = rd1; v.mack = mack;
        v.mrc = mrc; v.ra0 = ra0; v.ra1 = ra1; v.dat = dat; v.e = e;
        return v;
    endfunction

    task automatic apply_row(input vec_t v);
        rst            = v.rst;
        p0_bus_reqcyc  = v.c0;
        p1_bus_reqcyc  = v.c1;
        p0_bus_reqtag  = {1'b0, v.rd0, 11'h005};
        p1_bus_reqtag  = {1'b0, v.rd1, 11'h00A};
        p0_bus_req     = 64'h1000 + {56'h0, v.dat};
        p1_bus_req     = 64'h2040 + {56'h0, v.dat};
        m_bus_reqack   = v.mack;
        m_bus_respcyc  = v.mrc;
        m_bus_resp     = {56'h0, v.dat};
        m_bus_resptag  = 13'h0ABC;
        p0_bus_respack = v.ra0;
        p1_bus_respack = v.ra1;
    endtask

    initial begin
        logic [7:0] got[$];
        int k, stall;
        bit w1, w2;
        w1 = FIXED ? 1'b1 : 1'b0;
        w2 = 1'b1;

        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 8'h00, 6'b000000));
        // p0 read of 0x1000, eight response beats
        tbl.push_back(mk(0,1,0,1,0,0,0,0,0, 8'h00, 6'b000000));
        tbl.push_back(mk(0,1,0,1,0,1,0,0,0, 8'h00, 6'b110000));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(0,0,0,0,0,0,1,1,0, 8'(8'hA0 + i), 6'b000101));
        // p1 write of 0x2040; stray memory response while idle must not route
        tbl.push_back(mk(0,0,1,0,0,0,1,1,1, 8'h00, 6'b000000));
        tbl.push_back(mk(0,0,1,0,0,1,0,0,0, 8'h00, 6'b101000));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(0,0,1,0,0,1,0,0,0, 8'(8'hD0 + i), 6'b101000));
        // two simultaneous write requests in a row
        tbl.push_back(mk(0,1,1,0,0,0,0,0,0, 8'h00, 6'b000000));
        for (int i = 0; i < 9; i++) tbl.push_back(mk(0,1,1,0,0,1,0,0,0, 8'(i), {1'b1, !w1, w1, 3'b000}));
        tbl.push_back(mk(0,1,1,0,0,0,0,0,0, 8'h00, 6'b000000));
        for (int i = 0; i < 9; i++) tbl.push_back(mk(0,1,1,0,0,1,0,0,0, 8'(i), {1'b1, !w2, w2, 3'b000}));
        // reset during read beat 3, then a fresh p1 read granted in one cycle
        tbl.push_back(mk(0,1,0,1,0,0,0,0,0, 8'h00, 6'b000000));
        tbl.push_back(mk(0,1,0,1,0,1,0,0,0, 8'h00, 6'b110000));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,0,0,0,1,1,0, 8'(8'hA0 + i), 6'b000101));
        tbl.push_back(mk(1,0,0,0,0,0,1,1,0, 8'hA3, 6'b000101));
        tbl.push_back(mk(0,0,1,0,1,0,1,1,1, 8'h00, 6'b000000));
        tbl.push_back(mk(0,0,1,0,1,1,0,0,0, 8'h00, 6'b101000));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(0,0,0,0,0,0,1,0,1, 8'(8'hB0 + i), 6'b000011));
        tbl.push_back(mk(0,0,0,0,0,0,1,1,1, 8'h00, 6'b000000));
        // granted reqcyc dropped in the address phase: no m_bus_reqcyc, no progress
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0, 8'h00, 6'b000000));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0, 8'h00, 6'b010000));
        tbl.push_back(mk(0,1,0,0,0,1,0,0,0, 8'h00, 6'b110000));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(0,1,0,0,0,1,0,0,0, 8'(8'hC0 + i), 6'b110000));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 8'h00, 6'b000000));

        apply_row(mk(1,0,0,0,0,0,0,0,0, 8'h00, 6'b000000));
        repeat (3) @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            apply_row(tbl[i]);
            #1;
            chk($sformatf("row%0d", i), 237'({m_bus_reqcyc, p0_bus_reqack, p1_bus_reqack,
                                               p0_bus_respcyc, p1_bus_respcyc, m_bus_respack}), 237'(tbl[i].e));
            if (tbl[i].e[2]) chk($sformatf("row%0d_resp0", i), 237'(p0_bus_resp), 237'(tbl[i].dat));
            if (tbl[i].e[1]) chk($sformatf("row%0d_resp1", i), 237'(p1_bus_resp), 237'(tbl[i].dat));
            step();
        end

        // p0 read with a three-cycle response stall at beat 4
        apply_row(mk(0,1,0,1,0,0,0,0,0, 8'h00, 6'b000000));
        #1; step();
        m_bus_reqack = 1'b1;
        #1; step();
        p0_bus_reqcyc = 1'b0;
        m_bus_reqack  = 1'b0;
        k = 0;
        stall = 0;
        for (int i = 0; i < 11; i++) begin
            m_bus_respcyc  = 1'b1;
            m_bus_resp     = 64'(32'hA0 + k);
            p0_bus_respack = !(k == 4 && stall < 3);
            #1;
            if (!p0_bus_respack) begin
                chk("bp_hold_respack", 237'(m_bus_respack), 237'(0));
                stall++;
            end else if (p0_bus_respcyc) begin
                got.push_back(p0_bus_resp[7:0]);
                k++;
            end
            step();
        end
        p0_bus_respack = 1'b1;
        #1;
        chk("bp_no_extra_beat", 237'(p0_bus_respcyc), 237'(0));
        step();
        chk("bp_beat_count", 237'(got.size()), 237'(BEATS));
        for (int j = 0; j < got.size(); j++)
            chk($sformatf("bp_beat%0d", j), 237'(got[j]), 237'(8'hA0 + j));

        // randomized traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            rst            = ($urandom_range(0, 299) == 0);
            p0_bus_reqcyc  = 1'($urandom_range(0, 1));
            p1_bus_reqcyc  = 1'($urandom_range(0, 1));
            p0_bus_reqtag  = 13'($urandom);
            p1_bus_reqtag  = 13'($urandom);
            p0_bus_req     = {$urandom, $urandom};
            p1_bus_req     = {$urandom, $urandom};
            m_bus_reqack   = ($urandom_range(0, 9) < 6);
            m_bus_respcyc  = ($urandom_range(0, 9) < 6);
            m_bus_resp     = {$urandom, $urandom};
            m_bus_resptag  = 13'($urandom);
            p0_bus_respack = ($urandom_range(0, 9) < 7);
            p1_bus_respack = ($urandom_range(0, 9) < 7);
            #1;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
